// File: rtl/mac_seq.sv
// Job sequencer for the 3-tap signed MAC: loads three weights, streams features through
// the MAC and hands out one dot product per feature window on a ready/valid port.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | one-cycle MAC clear
//   LDW   | accepting the three weights
//   LDF   | accepting features until a full window is present
//   OUT   | presenting mac_out as a result
//   DONE  | one-cycle completion pulse
module mac_seq #(
    parameter int DATA_BIT = 16,
    parameter int LEN_BIT  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_BIT-1:0]      len,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_BIT-1:0]     w_data,
    input  logic                    f_valid,
    output logic                    f_ready,
    input  logic [DATA_BIT-1:0]     f_data,
    output logic                    mac_clear,
    output logic                    mac_w_w,
    output logic                    mac_if_w,
    output logic [DATA_BIT-1:0]     mac_w_in,
    output logic [DATA_BIT-1:0]     mac_if_in,
    input  logic [2*DATA_BIT+1:0]   mac_out,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_BIT+1:0]   res_data,
    output logic [LEN_BIT-1:0]      res_idx
);

    localparam logic [LEN_BIT-1:0] ONE   = LEN_BIT'(1);
    localparam logic [LEN_BIT-1:0] TWO   = LEN_BIT'(2);
    localparam logic [LEN_BIT-1:0] THREE = LEN_BIT'(3);

    typedef enum logic [2:0] {IDLE, CLR, LDW, LDF, OUT, DONE} state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic w_ready;
        logic f_ready;
        logic res_valid;
        logic mac_clear;
    } ctl_t;

    state_t             state;
    ctl_t               ctl;
    logic [LEN_BIT-1:0] len_q;
    logic [LEN_BIT-1:0] wcnt;
    logic [LEN_BIT-1:0] fcnt;
    logic [LEN_BIT-1:0] idx_q;
    logic               err_q;
    logic               w_acc;
    logic               f_acc;

    // Control outputs are decoded from the state being entered so they are registered.
    function automatic ctl_t ctl_of(input state_t s);
        ctl_t c;
        c           = '0;
        c.busy      = (s != IDLE);
        c.done      = (s == DONE);
        c.w_ready   = (s == LDW);
        c.f_ready   = (s == LDF);
        c.res_valid = (s == OUT);
        c.mac_clear = (s == CLR);
        return c;
    endfunction

    assign w_acc = w_valid & ctl.w_ready;
    assign f_acc = f_valid & ctl.f_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ctl   <= '0;
            len_q <= '0;
            wcnt  <= '0;
            fcnt  <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len >= THREE) begin
                            len_q <= len;
                            wcnt  <= '0;
                            fcnt  <= '0;
                            idx_q <= '0;
                            err_q <= 1'b0;
                            state <= CLR;
                            ctl   <= ctl_of(CLR);
                        end else begin
                            err_q <= 1'b1;
                            state <= DONE;
                            ctl   <= ctl_of(DONE);
                        end
                    end
                end
                CLR: begin
                    state <= LDW;
                    ctl   <= ctl_of(LDW);
                end
                LDW: begin
                    if (w_acc) begin
                        wcnt <= wcnt + ONE;
                        if (wcnt == TWO) begin
                            state <= LDF;
                            ctl   <= ctl_of(LDF);
                        end
                    end
                end
                LDF: begin
                    if (f_acc) begin
                        fcnt <= fcnt + ONE;
                        // fcnt never exceeds len, so fcnt+1 >= 3 is fcnt >= 2 without overflow
                        if (fcnt >= TWO) begin
                            state <= OUT;
                            ctl   <= ctl_of(OUT);
                        end
                    end
                end
                OUT: begin
                    if (res_ready) begin
                        idx_q <= idx_q + ONE;
                        if (fcnt == len_q) begin
                            state <= DONE;
                            ctl   <= ctl_of(DONE);
                        end else begin
                            state <= LDF;
                            ctl   <= ctl_of(LDF);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ctl   <= ctl_of(IDLE);
                end
                default: begin
                    state <= IDLE;
                    ctl   <= ctl_of(IDLE);
                end
            endcase
        end
    end

    assign busy      = ctl.busy;
    assign done      = ctl.done;
    assign err       = err_q;
    assign w_ready   = ctl.w_ready;
    assign f_ready   = ctl.f_ready;
    assign mac_clear = ctl.mac_clear;
    assign res_valid = ctl.res_valid;
    assign res_idx   = idx_q;

    assign mac_w_w   = w_acc;
    assign mac_if_w  = f_acc;
    assign mac_w_in  = w_acc ? w_data : '0;
    assign mac_if_in = f_acc ? f_data : '0;
    assign res_data  = ctl.res_valid ? mac_out : '0;

endmodule

// File: tb/tb_mac_seq.sv
// Directed bench for mac_seq: models the external 3-tap MAC, drives the weight/feature
// streams from queues and compares results against hand-computed dot products.
module tb_mac_seq;

    logic        clk, rst, start;
    logic [7:0]  len;
    logic        busy, done, err;
    logic        w_valid, w_ready, f_valid, f_ready;
    logic [15:0] w_data, f_data;
    logic        mac_clear, mac_w_w, mac_if_w;
    logic [15:0] mac_w_in, mac_if_in;
    logic [33:0] mac_out, res_data;
    logic        res_valid, res_ready;
    logic [7:0]  res_idx;

    mac_seq #(.DATA_BIT(16), .LEN_BIT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data),
        .mac_clear(mac_clear), .mac_w_w(mac_w_w), .mac_if_w(mac_if_w),
        .mac_w_in(mac_w_in), .mac_if_in(mac_if_in), .mac_out(mac_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // External MAC: the first weight written ends in slot 0, paired with the oldest feature.
    logic signed [15:0] mw0, mw1, mw2, mf0, mf1, mf2;
    logic signed [33:0] p0, p1, p2;
    always_ff @(posedge clk or posedge rst) begin
        if (rst || mac_clear) begin
            mw0 <= '0; mw1 <= '0; mw2 <= '0;
            mf0 <= '0; mf1 <= '0; mf2 <= '0;
        end else begin
            if (mac_w_w) begin
                mw0 <= mw1; mw1 <= mw2; mw2 <= mac_w_in;
            end
            if (mac_if_w) begin
                mf0 <= mf1; mf1 <= mf2; mf2 <= mac_if_in;
            end
        end
    end
    assign p0 = mw0 * mf0;
    assign p1 = mw1 * mf1;
    assign p2 = mw2 * mf2;
    assign mac_out = p0 + p1 + p2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stream drivers
    logic [15:0] wq[$];
    logic [15:0] fq[$];
    logic        w_acc_s, f_acc_s, f_toggle, f_gate;
    int          stall_idx, stall_left;

    initial begin
        w_valid = 1'b0; w_data = '0; w_acc_s = 1'b0;
        forever begin
            @(negedge clk);
            if (w_acc_s && wq.size() > 0) void'(wq.pop_front());
            w_valid = (wq.size() > 0);
            w_data  = '0;
            if (w_valid) w_data = wq[0];
            #4;
            w_acc_s = w_valid && w_ready;
        end
    end

    initial begin
        f_valid = 1'b0; f_data = '0; f_acc_s = 1'b0; f_gate = 1'b1;
        forever begin
            @(negedge clk);
            if (f_acc_s && fq.size() > 0) void'(fq.pop_front());
            f_gate  = f_toggle ? ~f_gate : 1'b1;
            f_valid = f_gate && (fq.size() > 0);
            f_data  = '0;
            if (f_valid) f_data = fq[0];
            #4;
            f_acc_s = f_valid && f_ready;
        end
    end

    initial begin
        res_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (res_valid && int'(res_idx) == stall_idx && stall_left > 0) begin
                res_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // Monitor, sampled one time unit before each rising edge
    longint res_q[$];
    int     idx_q[$];
    int     cnt_clear = 0, cnt_ww = 0, cnt_fw = 0, cnt_done = 0, cnt_rv = 0, cnt_busy = 0;
    int     cnt_stall = 0, cnt_hold_bad = 0, cnt_out_strobe = 0;
    logic   prev_stall = 1'b0;
    longint prev_data = 0;

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst) begin
                cnt_clear += int'(mac_clear);
                cnt_ww    += int'(mac_w_w);
                cnt_fw    += int'(mac_if_w);
                cnt_done  += int'(done);
                cnt_rv    += int'(res_valid);
                cnt_busy  += int'(busy);
                if (res_valid && (mac_clear || mac_w_w || mac_if_w)) cnt_out_strobe++;
                if (prev_stall && res_valid && longint'($signed(res_data)) != prev_data) cnt_hold_bad++;
                if (res_valid && !res_ready) cnt_stall++;
                if (res_valid && res_ready) begin
                    res_q.push_back(longint'($signed(res_data)));
                    idx_q.push_back(int'(res_idx));
                end
                prev_stall = res_valid && !res_ready;
                prev_data  = longint'($signed(res_data));
            end
        end
    end

    typedef struct packed {
        logic [15:0]      w0, w1, w2;
        int               n;
        logic [0:5][15:0] f;
        int               nres;
        longint           e0, e1, e2, e3;
    } vec_t;

    vec_t tbl[5];

    function automatic vec_t mk(input logic [15:0] w0, w1, w2, input int n,
                                input logic [15:0] f0, f1, f2, f3, f4, f5,
                                input int nres, input longint e0, e1, e2, e3);
        vec_t v;
        v.w0 = w0; v.w1 = w1; v.w2 = w2; v.n = n;
        v.f[0] = f0; v.f[1] = f1; v.f[2] = f2; v.f[3] = f3; v.f[4] = f4; v.f[5] = f5;
        v.nres = nres; v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3;
        return v;
    endfunction

    function automatic longint exp_of(input vec_t v, input int k);
        case (k)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    task automatic load(input vec_t v);
        wq.push_back(v.w0); wq.push_back(v.w1); wq.push_back(v.w2);
        for (int i = 0; i < v.n; i++) fq.push_back(v.f[i]);
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk({name, "_done_seen"}, longint'(seen), 1);
    endtask

    task automatic check_results(input string name, input vec_t v);
        chk({name, "_nres"}, res_q.size(), v.nres);
        for (int k = 0; k < v.nres && k < res_q.size(); k++) begin
            chk($sformatf("%s_res%0d", name, k), res_q[k], exp_of(v, k));
            chk($sformatf("%s_idx%0d", name, k), idx_q[k], k);
        end
    endtask

    // One job with start pulsed for a single cycle
    task automatic run_job(input string name, input vec_t v, input bit timing);
        int c0, w0, f0, d0, b0;
        res_q.delete(); idx_q.delete();
        load(v);
        c0 = cnt_clear; w0 = cnt_ww; f0 = cnt_fw; d0 = cnt_done; b0 = cnt_busy;
        @(negedge clk); start = 1'b1; len = 8'(v.n);
        @(negedge clk); start = 1'b0;
        chk({name, "_clr_pulse"}, mac_clear, 1);
        chk({name, "_err_clr"}, err, 0);
        wait_done(name, 300);
        chk({name, "_busy_in_done"}, busy, 1);
        @(posedge clk); #1;
        chk({name, "_busy_fall"}, busy, 0);
        chk({name, "_done_one"}, done, 0);
        check_results(name, v);
        chk({name, "_clears"}, cnt_clear - c0, 1);
        chk({name, "_wstrobes"}, cnt_ww - w0, 3);
        chk({name, "_fstrobes"}, cnt_fw - f0, v.n);
        chk({name, "_dones"}, cnt_done - d0, 1);
        if (timing) chk({name, "_cycles"}, cnt_busy - b0, 9 + 2 * (v.n - 3));
    endtask

    initial begin
        vec_t vb, va;
        int   c0, d0, r0, w0, f0, s0, h0, o0;
        bit   hit;

        f_toggle = 1'b0; stall_idx = -1; stall_left = 0;
        start = 1'b0; len = '0; rst = 1'b1;

        tbl[0] = mk(16'd1, 16'd2, 16'd3, 5, 16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd0,
                    3, 14, 20, 26, 0);
        tbl[1] = mk(16'h8000, 16'h8000, 16'h8000, 3, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0,
                    1, 64'sd3221225472, 0, 0, 0);
        tbl[2] = mk(16'h7FFF, 16'h7FFF, 16'h7FFF, 3, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0,
                    1, -64'sd3221127168, 0, 0, 0);
        tbl[3] = mk(16'hFFFF, 16'd0, 16'd2, 4, 16'd3, 16'hFFFC, 16'd5, 16'd7, 0, 0,
                    2, 7, 18, 0, 0);
        tbl[4] = mk(16'd1, 16'd1, 16'd1, 6, 16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60,
                    4, 60, 90, 120, 150);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", longint'(|{busy, done, err, w_ready, f_ready, mac_clear, mac_w_w, mac_if_w,
                                   res_valid, mac_w_in, mac_if_in, res_data, res_idx}), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);

        for (int i = 0; i < 5; i++) run_job($sformatf("row%0d", i), tbl[i], 1'b1);

        // Short job: error path, no MAC activity
        c0 = cnt_clear; w0 = cnt_ww; f0 = cnt_fw; r0 = cnt_rv; d0 = cnt_done;
        @(negedge clk); start = 1'b1; len = 8'd2;
        @(negedge clk); start = 1'b0;
        chk("short_err", err, 1);
        chk("short_done", done, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("short_err_held", err, 1);
        chk("short_busy", busy, 0);
        chk("short_strobes", (cnt_clear - c0) + (cnt_ww - w0) + (cnt_fw - f0), 0);
        chk("short_rv", cnt_rv - r0, 0);
        chk("short_dones", cnt_done - d0, 1);

        // Back-pressure on result 1 plus gapped features; also clears err
        stall_idx = 1; stall_left = 4; f_toggle = 1'b1;
        s0 = cnt_stall; h0 = cnt_hold_bad; o0 = cnt_out_strobe;
        run_job("bp", tbl[0], 1'b0);
        chk("bp_stall_cycles", cnt_stall - s0, 4);
        chk("bp_hold", cnt_hold_bad - h0, 0);
        chk("bp_out_strobes", cnt_out_strobe - o0, 0);
        chk("bp_err", err, 0);
        stall_idx = -1; f_toggle = 1'b0;

        // Reset during the second OUT
        res_q.delete(); idx_q.delete();
        load(tbl[0]);
        @(negedge clk); start = 1'b1; len = 8'd5;
        @(negedge clk); start = 1'b0;
        hit = 0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(posedge clk); #1;
            if (res_valid && res_idx == 8'd1) hit = 1;
        end
        chk("mrst_reach_out1", longint'(hit), 1);
        chk("mrst_res_before", longint'($signed(res_data)), 20);
        #2 rst = 1'b1;
        #1;
        chk("mrst_outs", longint'(|{busy, done, err, w_ready, f_ready, mac_clear, mac_w_w, mac_if_w,
                                   res_valid, mac_w_in, mac_if_in, res_data, res_idx}), 0);
        d0 = cnt_done;
        @(negedge clk);
        wq.delete(); fq.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        chk("mrst_idle", busy, 0);
        chk("mrst_no_done", cnt_done - d0, 0);
        run_job("mrst_new", tbl[1], 1'b1);

        // Back-to-back jobs with start held high
        va = mk(16'd1, 16'd2, 16'd3, 3, 16'd1, 16'd2, 16'd3, 0, 0, 0, 1, 14, 0, 0, 0);
        vb = mk(16'd2, 16'd0, 16'hFFFF, 3, 16'd4, 16'd5, 16'd6, 0, 0, 0, 1, 2, 0, 0, 0);
        res_q.delete(); idx_q.delete();
        load(va); load(vb);
        c0 = cnt_clear; d0 = cnt_done;
        @(negedge clk); start = 1'b1; len = 8'd3;
        wait_done("b2b_a", 100);
        @(posedge clk); #1;
        chk("b2b_idle_after_done", busy, 0);
        @(posedge clk); #1;
        chk("b2b_clr_b", mac_clear, 1);
        wait_done("b2b_b", 100);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_no_third", busy, 0);
        chk("b2b_clears", cnt_clear - c0, 2);
        chk("b2b_dones", cnt_done - d0, 2);
        chk("b2b_nres", res_q.size(), 2);
        if (res_q.size() == 2) begin
            chk("b2b_res_a", res_q[0], 14);
            chk("b2b_res_b", res_q[1], 2);
            chk("b2b_idx_b", idx_q[1], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencer for the 3-tap signed MAC unit: it drives the MAC's clear, weight-write and feature-write strobes, and collects one 34-bit dot product per feature window. Each job loads three weights, then streams `len` features through the MAC. The block returns `len-2` results on a ready/valid output port and sits between the feature/weight memories and the result buffer.

## Interface
- `DATA_BIT`, 16: width of weights, features and the MAC data ports.
- `LEN_BIT`, 8: width of the job length `len` and of the counters.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  job request; sampled only in IDLE.
- `len`  in  LEN_BIT  feature count of the job; latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  registered; set when a job starts with `len` < 3; cleared on the next accepted `start`.
- `w_valid` / `w_ready` / `w_data`  in / out / in (DATA_BIT)  weight stream.
- `f_valid` / `f_ready` / `f_data`  in / out / in (DATA_BIT)  feature stream.
- `mac_clear`, `mac_w_w`, `mac_if_w`  out  1  MAC control strobes.
- `mac_w_in`, `mac_if_in`  out  DATA_BIT  MAC data inputs.
- `mac_out`  in  2*DATA_BIT+2  MAC combinational sum.
- `res_valid` / `res_ready`  out / in  1  result handshake.
- `res_data`  out  2*DATA_BIT+2  signed result.
- `res_idx`  out  LEN_BIT  index of the current result, starting at 0.

## Operation
- States: IDLE, CLR, LDW, LDF, OUT, DONE.
- IDLE:
  - `start`=1 with `len`>=3: latch `len`, clear `wcnt`, `fcnt`, `res_idx` and `err`, go to CLR.
  - `start`=1 with `len`<3: set `err`, go to DONE.
  - `start` is ignored in every other state.
- CLR: `mac_clear`=1 for exactly one cycle, then go to LDW.
- LDW:
  - `w_ready`=1.
  - On `w_valid & w_ready`: `mac_w_w`=1 and `mac_w_in`=`w_data` in the same cycle; `wcnt`++.
  - After the third accept, go to LDF. The first weight accepted pairs with the oldest feature in the window.
- LDF:
  - `f_ready`=1.
  - On accept: `mac_if_w`=1 and `mac_if_in`=`f_data` in the same cycle; `fcnt`++.
  - If the new `fcnt`>=3, go to OUT; otherwise stay in LDF.
- OUT:
  - `res_valid`=1 and `res_data`=`mac_out`. No MAC strobes are issued, so `res_data` is stable while stalled.
  - On `res_ready`: `res_idx`++; go to DONE if `fcnt`==`len`, else go to LDF.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Outside their handshake cycles, all strobes are 0. `mac_w_in`/`mac_if_in` are 0 when their strobe is low, and `res_data`=0 when `res_valid`=0.
- Arithmetic: operands are two's complement. `res_data` is passed through unmodified from `mac_out`, with no saturation.

## Timing
- Reset: state=IDLE; counters=0; `busy`=`done`=`err`=0; all ready, valid and strobe outputs 0; all data outputs 0.
- `rst` asserted mid-job aborts immediately: no `done`, the partial result is discarded, and the MAC must be reset with the same `rst`.
- Accepted `start` at edge 0: CLR in cycle 1, LDW from cycle 2.
- With both streams always valid, a `len`=N job takes 1 (CLR) + 3 + 3 + 1 + 2(N-3) cycles to the last OUT, plus 1 DONE cycle.
- Result k is valid on the cycle after feature k+2 is written.
- Steady state is one result every 2 cycles.
- Back-pressure: each cycle `res_ready`=0 adds one OUT cycle; each cycle `w_valid`/`f_valid`=0 adds one LDW/LDF cycle.
- `len`=3 gives exactly one result. `len`=255 gives 253 results, `res_idx` 0..252 with no wrap.
- `start` asserted during DONE is ignored; a new job can be accepted in IDLE the next cycle.

## Test plan
- Basic job:
  - Stimulus: weights 1,2,3; `len`=5; features 1..5; `res_ready`=1.
  - Required: results 14, 20, 26 with `res_idx` 0,1,2; `done` pulses once; `busy` falls the following cycle.
- Signed extreme:
  - Stimulus: weights 0x8000 x3; features 0x8000 x3; `len`=3.
  - Required: `res_data`=3221225472.
  - Then weights 0x7FFF x3 with features 0x8000 x3: `res_data`=-3221127168.
- Back-pressure:
  - Stimulus: basic job with `res_ready` low for 4 cycles on result 1, and `f_valid` toggled every other cycle.
  - Required: `res_data` holds at 20 throughout the stall; no extra MAC strobes; the result sequence is unchanged.
- Short job:
  - Stimulus: `start` with `len`=2.
  - Required: `err`=1, one `done` pulse, no MAC strobes, no `res_valid`; the next valid `start` clears `err`.
- Mid-job reset:
  - Stimulus: assert `rst` during the second OUT.
  - Required: all outputs 0 in the same cycle; IDLE after release; a new `len`=3 job yields the correct single result.
- Back-to-back jobs:
  - Stimulus: two jobs with different weights; `start` held high throughout.
  - Required: `mac_clear` pulses once per job; the second job's results use only its own weights; `start` during DONE is ignored.
